uart_ext: RTL

//  Parametrised UART for the Wishbone UART peripheral: 5..8 data bits, none/even/odd parity,
//  1 or 2 stop bits, 16x oversampled RX with parity/frame/overrun error reporting.

---
 rtl/uart_ext_if.sv | 24 ++
 rtl/uart_ext.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ext_if.sv
// Bus-side handshake bundle between the Wishbone register wrapper and uart_ext.
interface uart_ext_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_avail;
    logic                 rx_ack;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_wr;
    logic                 tx_busy;

    modport master (
        input  rx_data, rx_avail, rx_parity_err, rx_frame_err, rx_overrun, tx_busy,
        output rx_ack, tx_data, tx_wr
    );

    modport slave (
        output rx_data, rx_avail, rx_parity_err, rx_frame_err, rx_overrun, tx_busy,
        input  rx_ack, tx_data, tx_wr
    );
endinterface

// File: rtl/uart_ext.sv
// Parametrised UART: 5..8 data bits, none/even/odd parity, 1/2 stop bits, 16x oversampled RX.
// Define UART_RX_FIFO_EN to buffer received words in a 2**FIFO_AW-deep FIFO.
module uart_ext #(
    parameter int unsigned FREQ_HZ   = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    uart_ext_if.slave  bus
);
    localparam int unsigned DIVISOR  = FREQ_HZ / BAUD / 16;
    localparam int unsigned DIV_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned TXC_W    = 6;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic        PAR_ODD  = (PARITY == 2);
    localparam logic [TXC_W-1:0] STOP_CNT = TXC_W'(STOP_BITS * 16 - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_AW < 1 || DIVISOR < 1) begin : g_bad_cfg
        $error("uart_ext: unsupported parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    // 16x baud tick
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    assign tick = (tick_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= DIV_W'(DIVISOR - 1);
        else               tick_cnt <= tick_cnt - DIV_W'(1);
    end

    // Receiver: synchroniser, mid-bit sampling FSM
    logic                 rxd_meta, rxd_sync;
    state_t               rx_state;
    logic [3:0]           rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_pbad;
    logic                 rx_sample, rx_deliver, rx_frame_bad, rx_drop;

    assign rx_sample    = tick && (rx_cnt == 4'd0) && (rx_state != S_IDLE);
    assign rx_deliver   = rx_sample && (rx_state == S_STOP) && rxd_sync;
    assign rx_frame_bad = rx_sample && (rx_state == S_STOP) && !rxd_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= '0;
            rx_pbad  <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            if (tick) begin
                if (rx_state == S_IDLE) begin
                    if (!rxd_sync) begin
                        rx_state <= S_START;
                        rx_cnt   <= 4'd7;
                    end
                end else if (rx_cnt != 4'd0) begin
                    rx_cnt <= rx_cnt - 4'd1;
                end else begin
                    rx_cnt <= 4'd15;
                    case (rx_state)
                        S_START: begin
                            if (rxd_sync) begin
                                rx_state <= S_IDLE;
                            end else begin
                                rx_state <= S_DATA;
                                rx_bit   <= 3'd0;
                                rx_pbad  <= 1'b0;
                            end
                        end
                        S_DATA: begin
                            rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
                            if (rx_bit == LAST_BIT) rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
                            else                    rx_bit   <= rx_bit + 3'd1;
                        end
                        S_PAR: begin
                            rx_pbad  <= (^rx_shift) ^ rxd_sync ^ PAR_ODD;
                            rx_state <= S_STOP;
                        end
                        default: rx_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 pop, push;

    assign pop     = bus.rx_ack && (count != '0);
    assign rx_drop = (count == (FIFO_AW + 1)'(DEPTH)) && !pop;
    assign push    = rx_deliver && !rx_drop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        end
    end

    assign bus.rx_avail = (count != '0);
    assign bus.rx_data  = bus.rx_avail ? mem[rd_ptr] : '0;
`else
    // A new word is only refused while the previous one is still unread
    assign rx_drop = bus.rx_avail && !bus.rx_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rx_data  <= '0;
            bus.rx_avail <= 1'b0;
        end else begin
            if (bus.rx_ack) bus.rx_avail <= 1'b0;
            if (rx_deliver && !rx_drop) begin
                bus.rx_data  <= rx_shift;
                bus.rx_avail <= 1'b1;
            end
        end
    end
`endif

    // Sticky error flags; a flag raised together with rx_ack survives the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rx_parity_err <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_overrun    <= 1'b0;
        end else begin
            if (bus.rx_ack) begin
                bus.rx_parity_err <= 1'b0;
                bus.rx_frame_err  <= 1'b0;
                bus.rx_overrun    <= 1'b0;
            end
            if (rx_frame_bad)            bus.rx_frame_err  <= 1'b1;
            if (rx_deliver && rx_pbad)   bus.rx_parity_err <= 1'b1;
            if (rx_deliver && rx_drop)   bus.rx_overrun    <= 1'b1;
        end
    end

    // Transmitter: each bit held 16 ticks, stop held STOP_BITS*16 ticks
    state_t               tx_state;
    logic [TXC_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state    <= S_IDLE;
            uart_txd    <= 1'b1;
            bus.tx_busy <= 1'b0;
            tx_cnt      <= '0;
            tx_bit      <= 3'd0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else if (tx_state == S_IDLE) begin
            if (bus.tx_wr) begin
                tx_shift    <= bus.tx_data;
                tx_par      <= (^bus.tx_data) ^ PAR_ODD;
                tx_state    <= S_START;
                bus.tx_busy <= 1'b1;
                uart_txd    <= 1'b0;
                tx_cnt      <= TXC_W'(15);
            end
        end else if (tick) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - TXC_W'(1);
            end else begin
                tx_cnt <= TXC_W'(15);
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx_bit   <= 3'd0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                    S_DATA: begin
                        if (tx_bit != LAST_BIT) begin
                            tx_bit   <= tx_bit + 3'd1;
                            uart_txd <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end else if (PARITY != 0) begin
                            tx_state <= S_PAR;
                            uart_txd <= tx_par;
                        end else begin
                            tx_state <= S_STOP;
                            uart_txd <= 1'b1;
                            tx_cnt   <= STOP_CNT;
                        end
                    end
                    S_PAR: begin
                        tx_state <= S_STOP;
                        uart_txd <= 1'b1;
                        tx_cnt   <= STOP_CNT;
                    end
                    default: begin
                        tx_state    <= S_IDLE;
                        bus.tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
